// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory-access stage: op encodings, data memory size
// and the W-stage reset PC.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  localparam int unsigned DM_WORDS_DEFAULT = 4096;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  function automatic logic op_is_load(input mem_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/halfword out of the memory word and sign- or
// zero-extends it according to the load op; non-loads return 0.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  mem_op_e     op,
  output logic [31:0] word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword select ignores addr[0]; misalignment is judged by the caller.
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    word = 32'd0;
    case (op)
      OP_LW:  word = rdata;
      OP_LH:  word = {{16{half_sel[15]}}, half_sel};
      OP_LHU: word = {16'd0, half_sel};
      OP_LB:  word = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: word = {24'd0, byte_sel};
      default: word = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage front end of the data memory plus the M->W pipeline register.
// Define MEM_ALIGN_EXC_EN to treat misaligned word/halfword accesses as faults.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DM_WORDS = DM_WORDS_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [3:0]  m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_pc,
  input  logic [4:0]  m_rd,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  output logic        dm_memwrite,
  output logic [31:0] dm_writepc,
  input  logic [31:0] dm_rdata,
  output logic        w_valid,
  output logic        w_is_load,
  output logic [4:0]  w_rd,
  output logic [31:0] w_ldata,
  output logic [31:0] w_pc,
  output logic        w_exc
);

  // 33-bit limit so a full 4 GiB memory size cannot overflow the compare.
  localparam logic [32:0] DM_LIMIT = 33'(DM_WORDS) * 33'd4;

  mem_op_e     op;
  logic        is_load;
  logic        is_store;
  logic        out_of_range;
  logic        misalign;
  logic        fault;
  logic [31:0] ext_data;

  assign op       = mem_op_e'(m_op);
  assign is_load  = op_is_load(op);
  assign is_store = op_is_store(op);

  assign out_of_range = ({1'b0, m_addr} >= DM_LIMIT);

`ifdef MEM_ALIGN_EXC_EN
  always_comb begin
    misalign = 1'b0;
    case (op)
      OP_LW, OP_SW:          misalign = (m_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  misalign = m_addr[0];
      default:               misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign fault = (is_load | is_store) & (out_of_range | misalign);

  assign dm_addr    = m_addr;
  assign dm_wdata   = m_wdata;
  assign dm_writepc = m_pc;

  always_comb begin
    dm_byteen = 4'b0000;
    case (op)
      OP_SW:   dm_byteen = 4'b1111;
      OP_SH:   dm_byteen = m_addr[1] ? 4'b1100 : 4'b0011;
      OP_SB:   dm_byteen = 4'b0001 << m_addr[1:0];
      default: dm_byteen = 4'b0000;
    endcase
  end

  // A stalled store is retried every cycle; only the advancing cycle writes.
  assign dm_memwrite = m_valid & is_store & ~stall & ~reset & ~fault;

  mem_access_unit_load_extend u_load_extend (
    .rdata (dm_rdata),
    .addr  (m_addr[1:0]),
    .op    (op),
    .word  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid   <= 1'b0;
      w_is_load <= 1'b0;
      w_rd      <= 5'd0;
      w_ldata   <= 32'd0;
      w_pc      <= RESET_PC;
      w_exc     <= 1'b0;
    end else if (flush) begin
      w_valid   <= 1'b0;
      w_is_load <= 1'b0;
      w_exc     <= 1'b0;
    end else if (!stall) begin
      w_valid   <= m_valid;
      w_is_load <= m_valid & is_load;
      w_rd      <= m_rd;
      w_ldata   <= fault ? 32'd0 : ext_data;
      w_pc      <= m_pc;
      w_exc     <= m_valid & fault;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; expectations follow
// MEM_ALIGN_EXC_EN when it is defined for the build.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_pc;
  logic [4:0]  m_rd;
  logic        stall;
  logic        flush;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_byteen;
  logic        dm_memwrite;
  logic [31:0] dm_writepc;
  logic [31:0] dm_rdata;
  logic        w_valid;
  logic        w_is_load;
  logic [4:0]  w_rd;
  logic [31:0] w_ldata;
  logic [31:0] w_pc;
  logic        w_exc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk         (clk),
    .reset       (reset),
    .m_valid     (m_valid),
    .m_op        (m_op),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_pc        (m_pc),
    .m_rd        (m_rd),
    .stall       (stall),
    .flush       (flush),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_byteen   (dm_byteen),
    .dm_memwrite (dm_memwrite),
    .dm_writepc  (dm_writepc),
    .dm_rdata    (dm_rdata),
    .w_valid     (w_valid),
    .w_is_load   (w_is_load),
    .w_rd        (w_rd),
    .w_ldata     (w_ldata),
    .w_pc        (w_pc),
    .w_exc       (w_exc)
  );

  task automatic drive(input logic v, input mem_op_e op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc,
                       input logic [4:0] rd, input logic [31:0] rdata);
    m_valid = v; m_op = op; m_addr = addr; m_wdata = wdata;
    m_pc = pc; m_rd = rd; dm_rdata = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    tick();
    tick();
    n_cmp++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL reset_w_valid: got %b want 0", w_valid); end
    n_cmp++; if (w_pc !== 32'h0000_3000) begin n_err++; $display("FAIL reset_w_pc: got %h want 00003000", w_pc); end
    n_cmp++; if ({w_is_load, w_exc, w_rd, w_ldata} !== 39'd0) begin n_err++;
      $display("FAIL reset_w_fields: got load=%b exc=%b rd=%0d ldata=%h want all 0", w_is_load, w_exc, w_rd, w_ldata); end
    reset = 1'b0;
  endtask

  task automatic test_store_then_load();
    drive(1'b1, OP_SB, 32'h0000_0003, 32'h0000_00AB, 32'h0000_1000, 5'd0, 32'h0);
    n_cmp++; if (dm_byteen !== 4'b1000) begin n_err++; $display("FAIL sb_byteen: got %b want 1000", dm_byteen); end
    n_cmp++; if (dm_memwrite !== 1'b1) begin n_err++; $display("FAIL sb_memwrite: got %b want 1", dm_memwrite); end
    n_cmp++; if ({dm_addr, dm_wdata, dm_writepc} !== {32'h3, 32'hAB, 32'h1000}) begin n_err++;
      $display("FAIL sb_request: got addr=%h wdata=%h pc=%h want 00000003 000000ab 00001000", dm_addr, dm_wdata, dm_writepc); end
    tick();
    n_cmp++; if ({w_valid, w_is_load, w_pc} !== {1'b1, 1'b0, 32'h1000}) begin n_err++;
      $display("FAIL sb_w: got valid=%b load=%b pc=%h want 1 0 00001000", w_valid, w_is_load, w_pc); end
    drive(1'b1, OP_LW, 32'h0, 32'h0, 32'h0000_1004, 5'd7, 32'hAB00_0000);
    n_cmp++; if ({dm_memwrite, dm_byteen} !== 5'b0) begin n_err++;
      $display("FAIL lw_request: got we=%b be=%b want 0 0000", dm_memwrite, dm_byteen); end
    tick();
    n_cmp++; if (w_ldata !== 32'hAB00_0000) begin n_err++; $display("FAIL lw_ldata: got %h want ab000000", w_ldata); end
    n_cmp++; if ({w_valid, w_is_load, w_rd, w_pc, w_exc} !== {1'b1, 1'b1, 5'd7, 32'h1004, 1'b0}) begin n_err++;
      $display("FAIL lw_w: got valid=%b load=%b rd=%0d pc=%h exc=%b want 1 1 7 00001004 0", w_valid, w_is_load, w_rd, w_pc, w_exc); end
  endtask

  typedef struct { mem_op_e op; logic [31:0] addr; logic [31:0] rdata; logic [31:0] exp; } ld_vec_t;

  task automatic test_load_extend();
    ld_vec_t v [7];
    v[0] = '{OP_LB,  32'h3, 32'hAB00_0000, 32'hFFFF_FFAB};
    v[1] = '{OP_LBU, 32'h3, 32'hAB00_0000, 32'h0000_00AB};
    v[2] = '{OP_LH,  32'h2, 32'h8001_1234, 32'hFFFF_8001};
    v[3] = '{OP_LHU, 32'h2, 32'h8001_1234, 32'h0000_8001};
    v[4] = '{OP_LH,  32'h0, 32'h8001_1234, 32'h0000_1234};
    v[5] = '{OP_LB,  32'h1, 32'h0000_7F00, 32'h0000_007F};
    v[6] = '{OP_LW,  32'h3FFC, 32'hCAFE_F00D, 32'hCAFE_F00D};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, v[i].op, v[i].addr, 32'h0, 32'h2000 + 32'(i * 4), 5'd9, v[i].rdata);
      tick();
      n_cmp++; if (w_ldata !== v[i].exp) begin n_err++;
        $display("FAIL load_ext[%0d]: got %h want %h", i, w_ldata, v[i].exp); end
      n_cmp++; if (w_exc !== 1'b0) begin n_err++; $display("FAIL load_exc[%0d]: got %b want 0", i, w_exc); end
    end
  endtask

  task automatic test_byteen();
    drive(1'b1, OP_SW, 32'h8, 32'h1234_5678, 32'h2100, 5'd0, 32'h0);
    n_cmp++; if ({dm_byteen, dm_memwrite} !== 5'b11111) begin n_err++;
      $display("FAIL sw_be: got be=%b we=%b want 1111 1", dm_byteen, dm_memwrite); end
    drive(1'b1, OP_SH, 32'hA, 32'h0000_5678, 32'h2104, 5'd0, 32'h0);
    n_cmp++; if ({dm_byteen, dm_memwrite} !== 5'b11001) begin n_err++;
      $display("FAIL sh_hi_be: got be=%b we=%b want 1100 1", dm_byteen, dm_memwrite); end
    drive(1'b1, OP_SB, 32'h5, 32'h0000_0078, 32'h2108, 5'd0, 32'h0);
    n_cmp++; if (dm_byteen !== 4'b0010) begin n_err++; $display("FAIL sb1_be: got %b want 0010", dm_byteen); end
    drive(1'b0, OP_SW, 32'h8, 32'h1234_5678, 32'h210C, 5'd0, 32'h0);
    n_cmp++; if (dm_memwrite !== 1'b0) begin n_err++; $display("FAIL invalid_sw_we: got %b want 0", dm_memwrite); end
    tick();
    n_cmp++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL invalid_w_valid: got %b want 0", w_valid); end
  endtask

  task automatic test_stall_store();
    drive(1'b1, OP_LW, 32'h10, 32'h0, 32'h0000_0100, 5'd3, 32'h1122_3344);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_SW, 32'h20, 32'hDEAD_BEEF, 32'h0000_0104, 5'd0, 32'h5555_5555);
      n_cmp++; if (dm_memwrite !== 1'b0) begin n_err++; $display("FAIL stall_we[%0d]: got %b want 0", i, dm_memwrite); end
      tick();
      n_cmp++; if ({w_valid, w_is_load, w_rd, w_ldata, w_pc} !== {1'b1, 1'b1, 5'd3, 32'h1122_3344, 32'h100}) begin n_err++;
        $display("FAIL stall_hold[%0d]: got valid=%b load=%b rd=%0d ldata=%h pc=%h want 1 1 3 11223344 00000100",
                 i, w_valid, w_is_load, w_rd, w_ldata, w_pc); end
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (dm_memwrite !== 1'b1) begin n_err++; $display("FAIL release_we: got %b want 1", dm_memwrite); end
    tick();
    n_cmp++; if ({w_valid, w_is_load, w_pc} !== {1'b1, 1'b0, 32'h104}) begin n_err++;
      $display("FAIL release_w: got valid=%b load=%b pc=%h want 1 0 00000104", w_valid, w_is_load, w_pc); end
    drive(1'b1, OP_NONE, 32'h20, 32'h0, 32'h0000_0108, 5'd0, 32'h0);
    n_cmp++; if (dm_memwrite !== 1'b0) begin n_err++; $display("FAIL after_release_we: got %b want 0", dm_memwrite); end
    tick();
  endtask

  task automatic test_flush_stall();
    drive(1'b1, OP_LW, 32'h30, 32'h0, 32'h0000_0200, 5'd4, 32'h0BAD_CAFE);
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    n_cmp++; if ({w_valid, w_is_load, w_exc} !== 3'b000) begin n_err++;
      $display("FAIL flush_stall: got valid=%b load=%b exc=%b want 0 0 0", w_valid, w_is_load, w_exc); end
  endtask

  task automatic test_reset_store();
    drive(1'b1, OP_LW, 32'h40, 32'h0, 32'h0000_0300, 5'd6, 32'h7777_7777);
    tick();
    drive(1'b1, OP_SW, 32'h44, 32'h1111_1111, 32'h0000_0304, 5'd0, 32'h0);
    reset = 1'b1;
    #1;
    n_cmp++; if (dm_memwrite !== 1'b0) begin n_err++; $display("FAIL reset_store_we: got %b want 0", dm_memwrite); end
    tick();
    reset = 1'b0;
    n_cmp++; if ({w_valid, w_is_load, w_rd, w_ldata, w_pc, w_exc} !== {1'b0, 1'b0, 5'd0, 32'h0, 32'h3000, 1'b0}) begin n_err++;
      $display("FAIL reset_store_w: got valid=%b load=%b rd=%0d ldata=%h pc=%h exc=%b want 0 0 0 00000000 00003000 0",
               w_valid, w_is_load, w_rd, w_ldata, w_pc, w_exc); end
  endtask

  task automatic test_align_and_range();
    logic exp_we;
    logic exp_exc;
`ifdef MEM_ALIGN_EXC_EN
    exp_we = 1'b0; exp_exc = 1'b1;
`else
    exp_we = 1'b1; exp_exc = 1'b0;
`endif
    drive(1'b1, OP_SH, 32'h0000_0001, 32'h0000_BEEF, 32'h0000_0400, 5'd0, 32'h0);
    n_cmp++; if (dm_memwrite !== exp_we) begin n_err++; $display("FAIL sh_misalign_we: got %b want %b", dm_memwrite, exp_we); end
    n_cmp++; if (dm_byteen !== 4'b0011) begin n_err++; $display("FAIL sh_misalign_be: got %b want 0011", dm_byteen); end
    tick();
    n_cmp++; if (w_exc !== exp_exc) begin n_err++; $display("FAIL sh_misalign_exc: got %b want %b", w_exc, exp_exc); end
    drive(1'b1, OP_LW, 32'h0000_4000, 32'h0, 32'h0000_0404, 5'd8, 32'hFFFF_FFFF);
    tick();
    n_cmp++; if ({w_exc, w_ldata} !== {1'b1, 32'h0}) begin n_err++;
      $display("FAIL lw_oor: got exc=%b ldata=%h want 1 00000000", w_exc, w_ldata); end
    drive(1'b1, OP_SW, 32'h0000_4000, 32'h1, 32'h0000_0408, 5'd0, 32'h0);
    n_cmp++; if (dm_memwrite !== 1'b0) begin n_err++; $display("FAIL sw_oor_we: got %b want 0", dm_memwrite); end
    tick();
    n_cmp++; if (w_exc !== 1'b1) begin n_err++; $display("FAIL sw_oor_exc: got %b want 1", w_exc); end
    drive(1'b1, OP_LW, 32'h0000_3FFC, 32'h0, 32'h0000_040C, 5'd8, 32'h0000_00A5);
    tick();
    n_cmp++; if ({w_exc, w_ldata} !== {1'b0, 32'h0000_00A5}) begin n_err++;
      $display("FAIL lw_top_in_range: got exc=%b ldata=%h want 0 000000a5", w_exc, w_ldata); end
  endtask

  initial begin
    test_reset();
    test_store_then_load();
    test_load_extend();
    test_byteen();
    test_stall_store();
    test_flush_stall();
    test_reset_store();
    test_align_and_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage front end that sits directly upstream of the data memory and also consumes its read data.
- Turns the M-stage load/store request into the data memory's address, write-data, byte-enable, write-strobe and write-PC inputs.
- Extracts and sign- or zero-extends load data from the memory's word read, and registers the result into the W stage.
- The M→W pipeline register is owned by this block, with stall/flush control.

Parameters:
- DM_WORDS, 4096, number of 32-bit words in the data memory. Addresses at or above DM_WORDS*4 are out of range.
- RESET_PC, 32'h0000_3000, value of w_pc after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  1  M-stage instruction is valid.
- m_op  in  4  memory op code: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB.
- m_addr  in  32  effective byte address.
- m_wdata  in  32  store source register value, unshifted.
- m_pc  in  32  PC of the M-stage instruction.
- m_rd  in  5  destination register for loads; pass-through for other ops.
- stall  in  1  hold the W register and suppress memory writes.
- flush  in  1  kill the instruction entering W.
- dm_addr  out  32  byte address to the data memory.
- dm_wdata  out  32  store data, low-aligned; the memory does the byte-lane placement.
- dm_byteen  out  4  byte-lane enables.
- dm_memwrite  out  1  write strobe.
- dm_writepc  out  32  PC of the store, for the memory's write trace.
- dm_rdata  in  32  word read from the memory, combinational in the same cycle.
- w_valid  out  1  W-stage entry valid.
- w_is_load  out  1  W-stage entry is a load.
- w_rd  out  5  W-stage destination register.
- w_ldata  out  32  extended load result.
- w_pc  out  32  W-stage PC.
- w_exc  out  1  W-stage entry faulted.

Behaviour:
- Request side (combinational from M inputs):
  - dm_addr = m_addr; dm_wdata = m_wdata; dm_writepc = m_pc.
- Byte enables:
  - SW → 4'b1111.
  - SH → 4'b0011 if m_addr[1]==0, else 4'b1100.
  - SB → 4'b0001 << m_addr[1:0].
  - All other ops → 4'b0000.
- Write strobe:
  - dm_memwrite = m_valid & store-op & ~stall & ~reset & ~fault.
  - With stall=1 the store is not written. It is written exactly once, in the cycle it advances.
- Load extraction from dm_rdata:
  - LB/LBU select byte m_addr[1:0]; LB sign-extends from bit 7, LBU zero-extends.
  - LH/LHU select halfword m_addr[1]; LH sign-extends from bit 15, LHU zero-extends.
  - LW passes the word through.
  - Non-load ops → 0.
- Out of range: address ≥ DM_WORDS*4 sets fault regardless of the optional feature.
- W register update priority, highest first:
  1. reset: w_valid=0, w_is_load=0, w_rd=0, w_ldata=0, w_pc=RESET_PC, w_exc=0.
  2. flush: w_valid=0, w_is_load=0, w_exc=0; other fields don't-care but held.
  3. stall: all W fields hold.
  4. Otherwise capture: w_valid=m_valid, w_is_load, w_rd, extended data, m_pc, fault.
- Latency: load data appears on w_ldata one cycle after the M cycle; no further stages.
- Faults:
  - A faulted load gives w_ldata=0 and w_exc=1.
  - A faulted store writes nothing.
- Simultaneous events:
  - flush+stall → flush wins.
  - Reset mid-store → no write that cycle.
  - m_valid=0 → no write; w_valid=0 next cycle.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - Misalignment is a fault: LW/SW with m_addr[1:0]≠0, or LH/LHU/SH with m_addr[0]≠0.
  - Faulted stores are suppressed; faulted loads return 0 with w_exc=1.
- Undefined:
  - Ignored address bits are treated as 0: LW/SW ignore bits [1:0], halfword ops ignore bit 0.
  - w_exc reflects only out-of-range faults.

Decomposition:
- Shared constants header (alongside the CPU parameter header):
  - m_op encodings: NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8.
  - DM_WORDS default.
  - RESET_PC.
- One natural sub-module, load_extend: combinational; takes rdata, addr[1:0] and op, returns the extended word.

Test Plan:
- SB at 0x0000_0003, m_wdata=0x0000_00AB → dm_byteen=4'b1000, dm_memwrite=1. Subsequent LW at 0x0 with dm_rdata=0xAB00_0000 → w_ldata=0xAB00_0000 next cycle.
- LB at 0x0000_0003, dm_rdata=0xAB00_0000 → w_ldata=0xFFFF_FFAB; LBU at the same address → w_ldata=0x0000_00AB.
- LH at 0x0000_0002, dm_rdata=0x8001_1234 → w_ldata=0xFFFF_8001; LHU → 0x0000_8001.
- SW with stall=1 held 3 cycles then released → dm_memwrite=0 for 3 cycles, then 1 for exactly one cycle. W fields frozen during the stall.
- flush=1 and stall=1 in the same cycle with a valid LW → w_valid=0 next cycle. Reset asserted during a valid SW → dm_memwrite=0, all W outputs at reset values.
- With MEM_ALIGN_EXC_EN: SH at 0x0000_0001 → dm_memwrite=0, w_exc=1 next cycle. Without it → dm_byteen=4'b0011, write occurs, w_exc=0. LW at 0x0000_4000 (out of range) → w_exc=1, w_ldata=0 in both builds.
